// File: rtl/bp_update_scheduler.sv
// Branch predictor table write scheduler.
// Sweeps the BTB/counter tables to the invalid state after reset or on a
// clear request, then drains queued execute-stage branch outcomes through
// the single table write port, one entry per cycle.
module bp_update_scheduler #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            upd_valid,
    input  logic [WORD_SIZE-1:0]            upd_pc,
    input  logic [WORD_SIZE-1:0]            upd_target,
    input  logic                            upd_taken,
    input  logic                            upd_cond,
    output logic                            upd_ready,
    input  logic                            clear_req,
    input  logic                            table_stall,
    output logic                            wr_en,
    output logic [INDEX_BITS-1:0]           wr_index,
    output logic [WORD_SIZE-INDEX_BITS-1:0] wr_tag,
    output logic [WORD_SIZE-1:0]            wr_target,
    output logic [1:0]                      wr_cnt_op,
    output logic                            busy,
    output logic                            init_done,
    output logic                            overflow
);

    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;
    localparam logic [INDEX_BITS-1:0] LAST_IDX  = '1;
    localparam logic [CNT_BITS-1:0]   DEPTH_CNT = CNT_BITS'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_CLEAR
    } state_e;

    state_e                state_q;
    logic [INDEX_BITS-1:0] sweep_idx_q;
    logic [PTR_BITS-1:0]   head_q;
    logic [PTR_BITS-1:0]   tail_q;
    logic [CNT_BITS-1:0]   count_q;
    logic                  overflow_q;

    logic [WORD_SIZE-1:0]  pc_mem_q    [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]  tgt_mem_q   [FIFO_DEPTH];
    logic                  taken_mem_q [FIFO_DEPTH];
    logic                  cond_mem_q  [FIFO_DEPTH];

    logic sweeping;
    logic empty;
    logic full;
    logic clear_go;
    logic push;
    logic pop;

    // Handshake, write-enable and queue control. Outputs are gated by reset_n
    // so the table sees no write and no acceptance while reset is held.
    always_comb begin
        sweeping  = (state_q != ST_RUN);
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_CNT);
        clear_go  = (state_q == ST_RUN) && clear_req;
        upd_ready = reset_n && !full;
        push      = upd_valid && upd_ready && !clear_go;
        if (sweeping) begin
            wr_en = reset_n && !table_stall;
        end else begin
            // A clear flushes the head too, so it must not reach the table.
            wr_en = reset_n && !empty && !table_stall && !clear_go;
        end
        pop       = wr_en && !sweeping;
        busy      = sweeping || !empty;
        init_done = (state_q == ST_RUN);
        overflow  = overflow_q;
    end

    // Write candidate: invalid entry while sweeping, queue head while running.
    always_comb begin
        if (sweeping) begin
            wr_index  = sweep_idx_q;
            wr_tag    = '0;
            wr_target = '1;
            wr_cnt_op = 2'b11;
        end else begin
            wr_index  = pc_mem_q[head_q][INDEX_BITS-1:0];
            wr_tag    = pc_mem_q[head_q][WORD_SIZE-1:INDEX_BITS];
            wr_target = tgt_mem_q[head_q];
            wr_cnt_op = (cond_mem_q[head_q] && !taken_mem_q[head_q]) ? 2'b10 : 2'b01;
        end
    end

    // Queue storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]    <= upd_pc;
            tgt_mem_q[tail_q]   <= upd_target;
            taken_mem_q[tail_q] <= upd_taken;
            cond_mem_q[tail_q]  <= upd_cond;
        end
    end

    // Sequencer state, sweep index, queue pointers and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else if (clear_go) begin
            state_q     <= ST_CLEAR;
            sweep_idx_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (sweeping && wr_en) begin
                if (sweep_idx_q == LAST_IDX) begin
                    state_q     <= ST_RUN;
                    sweep_idx_q <= '0;
                end else begin
                    sweep_idx_q <= sweep_idx_q + INDEX_BITS'(1);
                end
            end
            if (push) begin
                tail_q <= tail_q + PTR_BITS'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
            if (upd_valid && !upd_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench for bp_update_scheduler against a queue-based model.
module tb_bp_update_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic [15:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        upd_cond = 1'b0;
    logic        clear_req = 1'b0;
    logic        table_stall = 1'b0;
    logic        upd_ready;
    logic        wr_en;
    logic [7:0]  wr_index;
    logic [7:0]  wr_tag;
    logic [15:0] wr_target;
    logic [1:0]  wr_cnt_op;
    logic        busy;
    logic        init_done;
    logic        overflow;

    int cmp_count = 0;
    int err_count = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] target;
        logic        taken;
        logic        cond;
    } upd_t;

    // Reference model: pending updates, sweep position, mode, sticky flag.
    upd_t m_q[$];
    bit   m_run;
    int   m_pos;
    bit   m_ovf;
    bit   exp_dv;

    always #5 clk = ~clk;

    bp_update_scheduler #(
        .WORD_SIZE (16),
        .INDEX_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .upd_cond   (upd_cond),
        .upd_ready  (upd_ready),
        .clear_req  (clear_req),
        .table_stall(table_stall),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_tag     (wr_tag),
        .wr_target  (wr_target),
        .wr_cnt_op  (wr_cnt_op),
        .busy       (busy),
        .init_done  (init_done),
        .overflow   (overflow)
    );

    function automatic void model_reset();
        m_q.delete();
        m_run = 1'b0;
        m_pos = 0;
        m_ovf = 1'b0;
    endfunction

    // Expected {wr_en, index, tag, target, op, ready, busy, init_done, overflow}.
    function automatic logic [38:0] model_expect();
        logic       we;
        logic [7:0] idx;
        logic [7:0] tag;
        logic [15:0] tgt;
        logic [1:0] op;
        logic       rdy;
        idx = '0; tag = '0; tgt = '0; op = '0; exp_dv = 1'b0;
        if (reset_n !== 1'b1) begin
            return {1'b0, 34'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        end
        rdy = (m_q.size() < 4);
        if (!m_run) begin
            we = !table_stall;
            idx = 8'(m_pos); tag = 8'h00; tgt = 16'hFFFF; op = 2'b11; exp_dv = 1'b1;
        end else begin
            we = (m_q.size() > 0) && !table_stall && !clear_req;
            if (m_q.size() > 0) begin
                exp_dv = 1'b1;
                idx = m_q[0].pc[7:0];
                tag = m_q[0].pc[15:8];
                tgt = m_q[0].target;
                op  = !m_q[0].cond ? 2'b01 : (m_q[0].taken ? 2'b01 : 2'b10);
            end
        end
        return {we, idx, tag, tgt, op, rdy, (!m_run || (m_q.size() > 0)), m_run, m_ovf};
    endfunction

    function automatic logic [38:0] obs_vec(bit dv);
        return {wr_en, dv ? wr_index : 8'h00, dv ? wr_tag : 8'h00,
                dv ? wr_target : 16'h0000, dv ? wr_cnt_op : 2'b00,
                upd_ready, busy, init_done, overflow};
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    function automatic void model_step();
        bit rdy;
        bit we;
        if (reset_n !== 1'b1) begin
            model_reset();
            return;
        end
        rdy = (m_q.size() < 4);
        if (m_run && clear_req) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_run = 1'b0;
            m_pos = 0;
            return;
        end
        if (upd_valid && !rdy) m_ovf = 1'b1;
        we = !table_stall && (!m_run || (m_q.size() > 0));
        if (!m_run) begin
            if (we) begin
                m_pos++;
                if (m_pos == 256) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end
        end else if (we) begin
            void'(m_q.pop_front());
        end
        if (upd_valid && rdy)
            m_q.push_back('{pc: upd_pc, target: upd_target, taken: upd_taken, cond: upd_cond});
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0; clear_req = 1'b0; table_stall = 1'b0;
    endtask

    task automatic test_reset();
        logic [38:0] e, o;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'($urandom_range(0, 1));
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, o, e);
            end
            tick();
        end
        upd_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_init_sweep();
        logic [38:0] e, o;
        int writes;
        writes = 0;
        for (int i = 0; i < 257; i++) begin
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL init_sweep cyc=%0d got=%h exp=%h", i, o, e);
            end
            if (wr_en === 1'b1 && wr_cnt_op === 2'b11) writes++;
            tick();
        end
        cmp_count++;
        if (writes !== 256 || init_done !== 1'b1) begin
            err_count++;
            $display("FAIL init_len writes=%0d init_done=%b required 256/1", writes, init_done);
        end
    endtask

    task automatic test_single_update();
        logic [38:0] e, o;
        upd_valid = 1'b1; upd_pc = 16'h1234; upd_target = 16'h1240;
        upd_cond = 1'b1; upd_taken = 1'b0;
        #1;
        e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
        if (o !== e) begin
            err_count++;
            $display("FAIL single_push got=%h exp=%h", o, e);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        cmp_count++;
        if ({wr_en, wr_index, wr_tag, wr_target, wr_cnt_op} !== {1'b1, 8'h34, 8'h12, 16'h1240, 2'b10}) begin
            err_count++;
            $display("FAIL single_write got=%b/%h/%h/%h/%b required 1/34/12/1240/10",
                     wr_en, wr_index, wr_tag, wr_target, wr_cnt_op);
        end
        tick();
        #1;
        cmp_count++;
        if ({busy, wr_en} !== 2'b00) begin
            err_count++;
            $display("FAIL single_idle busy=%b wr_en=%b required 0/0", busy, wr_en);
        end
    endtask

    task automatic test_overflow();
        logic [38:0] e, o;
        int writes;
        table_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            upd_valid = 1'b1; upd_pc = 16'($urandom); upd_target = 16'($urandom);
            upd_cond = 1'($urandom_range(0, 1)); upd_taken = 1'($urandom_range(0, 1));
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL ovf_fill cyc=%0d got=%h exp=%h", i, o, e);
            end
            tick();
        end
        upd_valid = 1'b0;
        #1;
        cmp_count++;
        if ({upd_ready, overflow} !== 2'b01) begin
            err_count++;
            $display("FAIL ovf_flag ready=%b overflow=%b required 0/1", upd_ready, overflow);
        end
        table_stall = 1'b0;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", i, o, e);
            end
            if (wr_en === 1'b1) writes++;
            tick();
        end
        cmp_count++;
        if (writes !== 4) begin
            err_count++;
            $display("FAIL ovf_drain_count got=%0d required 4", writes);
        end
    endtask

    task automatic test_clear();
        logic [38:0] e, o;
        int sweep_writes;
        table_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            upd_valid = 1'b1; upd_pc = 16'($urandom); upd_target = 16'($urandom);
            upd_cond = 1'b0; upd_taken = 1'b0;
            tick();
        end
        table_stall = 1'b0; clear_req = 1'b1;
        upd_valid = 1'b1; upd_pc = 16'($urandom);
        #1;
        e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
        if (o !== e || wr_en !== 1'b0) begin
            err_count++;
            $display("FAIL clear_cycle got=%h exp=%h wr_en=%b", o, e, wr_en);
        end
        tick();
        clear_req = 1'b0; upd_valid = 1'b0;
        #1;
        cmp_count++;
        if ({overflow, init_done} !== 2'b00) begin
            err_count++;
            $display("FAIL clear_entry overflow=%b init_done=%b required 0/0", overflow, init_done);
        end
        sweep_writes = 0;
        for (int i = 0; i < 257; i++) begin
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL clear_sweep cyc=%0d got=%h exp=%h", i, o, e);
            end
            if (wr_en === 1'b1 && wr_cnt_op === 2'b11) sweep_writes++;
            tick();
        end
        #1;
        cmp_count++;
        if (sweep_writes !== 256 || busy !== 1'b0) begin
            err_count++;
            $display("FAIL clear_done writes=%0d busy=%b required 256/0", sweep_writes, busy);
        end
    endtask

    task automatic test_stall_sweep();
        logic [38:0] e, o;
        int cycles;
        int nxt;
        reset_n = 1'b0; model_reset(); idle_inputs();
        tick();
        reset_n = 1'b1;
        cycles = 0; nxt = 0;
        for (int i = 0; i < 600; i++) begin
            table_stall = (i % 2 == 0);
            #1;
            if (init_done === 1'b1) break;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL stall_sweep cyc=%0d got=%h exp=%h", i, o, e);
            end
            if (wr_en === 1'b1) begin
                cmp_count++;
                if (wr_index !== 8'(nxt)) begin
                    err_count++;
                    $display("FAIL stall_order got=%h required %h", wr_index, 8'(nxt));
                end
                nxt++;
            end
            cycles++;
            tick();
        end
        table_stall = 1'b0;
        cmp_count++;
        if (cycles !== 512 || nxt !== 256) begin
            err_count++;
            $display("FAIL stall_len cycles=%0d writes=%0d required 512/256", cycles, nxt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [38:0] e, o;
        reset_n = 1'b0; model_reset(); idle_inputs();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            upd_valid = (i % 40 == 0); upd_pc = 16'($urandom); upd_target = 16'($urandom);
            tick();
        end
        upd_valid = 1'b0;
        #1;
        e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
        if (o !== e || wr_index !== 8'd100) begin
            err_count++;
            $display("FAIL mid_sweep_pos got=%h exp=%h idx=%0d", o, e, wr_index);
        end
        #1;
        reset_n = 1'b0; model_reset();
        #1;
        cmp_count++;
        if ({wr_en, upd_ready, busy, init_done, overflow} !== 5'b00100) begin
            err_count++;
            $display("FAIL mid_reset got=%b required 00100",
                     {wr_en, upd_ready, busy, init_done, overflow});
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 258; i++) begin
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL restart_sweep cyc=%0d got=%h exp=%h", i, o, e);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [38:0] e, o;
        for (int i = 0; i < 5000; i++) begin
            if (reset_n && $urandom_range(0, 1999) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else begin
                reset_n = 1'b1;
            end
            upd_valid   = ($urandom_range(0, 99) < 40);
            upd_pc      = 16'($urandom);
            upd_target  = 16'($urandom);
            upd_taken   = 1'($urandom_range(0, 1));
            upd_cond    = 1'($urandom_range(0, 1));
            table_stall = ($urandom_range(0, 99) < 25);
            clear_req   = ($urandom_range(0, 799) == 0);
            #1;
            e = model_expect(); o = obs_vec(exp_dv); cmp_count++;
            if (o !== e) begin
                err_count++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, o, e);
            end
            tick();
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_sweep();
        test_single_update();
        test_overflow();
        test_clear();
        test_stall_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
Sequences all writes into the branch predictor tables: the BTB entries (8-bit tag plus 16-bit target) and the 2-bit counters (256 entries, 8-bit index).
- After reset, or on a clear request, it sweeps every entry to the invalid state (tag 0, target 16'hFFFF, counter 0).
- In normal operation it queues branch outcomes resolved in the execute stage and drains them, one per cycle, through the single table write port.
- Queueing decouples the resolve stage from table-port stalls and from init sweeps.

Parameters:
WORD_SIZE, 16, width of PC and target
INDEX_BITS, 8, table index width (entries = 2**INDEX_BITS); tag = PC[WORD_SIZE-1:INDEX_BITS]
FIFO_DEPTH, 4, number of pending update entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
upd_valid  in  1  resolved branch/jump outcome present this cycle
upd_pc  in  WORD_SIZE  PC of the resolved instruction
upd_target  in  WORD_SIZE  taken-path target address
upd_taken  in  1  actual outcome (used only when upd_cond=1)
upd_cond  in  1  1 = conditional branch (BNE/BEQ/BGZ/BLZ), 0 = unconditional jump
upd_ready  out  1  queue can accept an entry this cycle
clear_req  in  1  one-cycle request to re-invalidate all tables
table_stall  in  1  table write port unavailable this cycle
wr_en  out  1  table write occurs at this rising edge
wr_index  out  INDEX_BITS  entry index
wr_tag  out  WORD_SIZE-INDEX_BITS  tag to store
wr_target  out  WORD_SIZE  target to store
wr_cnt_op  out  2  00 hold, 01 saturating inc, 10 saturating dec, 11 force 0
busy  out  1  sweep in progress or queue non-empty
init_done  out  1  state is RUN
overflow  out  1  sticky: an update was dropped

Behaviour:
- States: INIT, RUN, CLEAR.
- Reset (async, reset_n=0):
  - state=INIT, sweep_idx=0, queue empty, overflow=0.
  - Outputs during reset: wr_en=0, init_done=0, upd_ready=0, busy=1.
- INIT and CLEAR (sweep):
  - Write candidate each cycle: wr_index=sweep_idx, wr_tag=0, wr_target=16'hFFFF, wr_cnt_op=11.
  - wr_en = !table_stall.
  - sweep_idx increments only on edges where wr_en=1. A stalled cycle holds the index.
  - After the write of index 2**INDEX_BITS-1, the next state is RUN and sweep_idx returns to 0.
  - An unstalled sweep therefore takes exactly 256 cycles; init_done rises in cycle 256 after reset release.
- RUN:
  - Write candidate is the queue head: wr_index=head.pc[7:0], wr_tag=head.pc[15:8], wr_target=head.target.
  - wr_cnt_op = head.cond ? (head.taken ? 01 : 10) : 01.
  - wr_en = !empty && !table_stall. The head pops on any edge where wr_en=1.
- wr_* outputs are combinational from state, sweep_idx and queue head. When wr_en=0 they hold their candidate values, and the table must ignore them.
- Queue:
  - upd_ready = !full (after reset is released), in every state.
  - An entry is pushed when upd_valid && upd_ready. Entries may accumulate during a sweep and drain in RUN.
  - Latency: an entry accepted at edge N is visible on wr_en no earlier than cycle N+1.
  - Push and pop on the same edge are both honoured; the count stays the same.
  - upd_ready is computed from the pre-edge count, so a full queue refuses a push even if it pops that cycle.
- Overflow: upd_valid && !upd_ready sets overflow (sticky). The entry is dropped. overflow is cleared only by reset or by entry into CLEAR.
- clear_req:
  - In RUN: the next state is CLEAR. The queue is flushed, including the head even if it would be written that edge (wr_en is forced to 0 in that cycle). overflow is cleared and sweep_idx starts at 0.
  - A push arriving in the same cycle as clear_req is discarded (not counted as overflow).
  - clear_req is ignored in INIT and CLEAR.
- busy = (state != RUN) || !empty. init_done = (state == RUN).
- Pointer arithmetic wraps modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-sweep or mid-drain: the queue is discarded and the sweep restarts at index 0.

Test Plan:
- Release reset, table_stall=0 → wr_en high for 256 consecutive cycles; wr_index runs 0..255; wr_target=FFFF; wr_cnt_op=11; init_done rises in cycle 256.
- In RUN, push upd_pc=16'h1234, target=16'h1240, cond=1, taken=0 → next cycle: wr_en=1, wr_index=8'h34, wr_tag=8'h12, wr_target=16'h1240, wr_cnt_op=10; busy drops afterwards.
- Hold table_stall=1 in RUN and push 4 entries → upd_ready=0; a 5th upd_valid sets overflow=1. Release the stall → 4 writes in push order, then wr_en=0.
- table_stall toggled every cycle during INIT → sweep takes 512 cycles; no index skipped or repeated.
- With 2 entries queued, pulse clear_req → wr_en=0 that cycle; queued entries never written; overflow=0; 256-entry sweep follows.
- Assert reset_n=0 at sweep index 100 → outputs return to reset values immediately; after release the sweep restarts at index 0.
